vector_dp_sequencer: RTL and testbench

//  Issue controller for the vector datapath: accepts 32-bit vector instructions over a valid/ready handshake,

---
 rtl/vdp_seq_pkg.sv | 50 +++++
 rtl/vdp_seq_decode.sv | 41 ++++
 rtl/vector_dp_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_vector_dp_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_seq_pkg.sv
// Shared definitions for the vector datapath issue sequencer.
//   - sequencer FSM state encoding
//   - V_Mode lane/mode codes
//   - instruction field bit positions
//   - fixed opcodes and the statistics counter width
//   - is_mac(): true for the two-phase multiply-accumulate modes
package vdp_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMul,
        StAdd
    } state_e;

    typedef enum logic [2:0] {
        ModeNib4    = 3'b000,
        ModeByte8   = 3'b001,
        ModeWord16  = 3'b010,
        ModeDword32 = 3'b011,
        ModeQword64 = 3'b100,
        ModeMac4    = 3'b101,
        ModeMac8    = 3'b110,
        ModeMac16   = 3'b111
    } v_mode_e;

    localparam logic [4:0] MUL_OP     = 5'h0A;
    localparam logic [4:0] ILLEGAL_OP = 5'h1F;
    localparam int unsigned CNT_W     = 16;

    // Instruction field positions: msb/lsb of each field
    localparam int unsigned VModeMsb = 31;
    localparam int unsigned VModeLsb = 29;
    localparam int unsigned AluOpMsb = 28;
    localparam int unsigned AluOpLsb = 24;
    localparam int unsigned WAddrMsb = 23;
    localparam int unsigned WAddrLsb = 19;
    localparam int unsigned RAddrMsb = 18;
    localparam int unsigned RAddrLsb = 14;
    localparam int unsigned SAddrMsb = 13;
    localparam int unsigned SAddrLsb = 9;
    localparam int unsigned SSelBit  = 8;
    localparam int unsigned ImmMsb   = 7;
    localparam int unsigned ImmLsb   = 0;

    function automatic logic is_mac(input logic [2:0] mode);
        return (mode == ModeMac4) || (mode == ModeMac8) || (mode == ModeMac16);
    endfunction

endpackage

// File: rtl/vdp_seq_decode.sv
// Combinational instruction decoder for the vector datapath sequencer.
// Ports:
//   instr_i       32-bit instruction word
//   v_mode_o      lane/mode select field
//   alu_op_o      ALU opcode field
//   w_addr_o, r_addr_o, s_addr_o   regfile address fields
//   s_sel_o       S operand select
//   ds_o          immediate replicated across all 8 bytes
//   is_mac_o      instruction is a two-phase MAC
//   is_illegal_o  instruction carries the reserved opcode
module vdp_seq_decode
    import vdp_seq_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [2:0]  v_mode_o,
    output logic [4:0]  alu_op_o,
    output logic [4:0]  w_addr_o,
    output logic [4:0]  r_addr_o,
    output logic [4:0]  s_addr_o,
    output logic        s_sel_o,
    output logic [63:0] ds_o,
    output logic        is_mac_o,
    output logic        is_illegal_o
);

    logic [7:0] imm;

    always_comb begin
        v_mode_o     = instr_i[VModeMsb:VModeLsb];
        alu_op_o     = instr_i[AluOpMsb:AluOpLsb];
        w_addr_o     = instr_i[WAddrMsb:WAddrLsb];
        r_addr_o     = instr_i[RAddrMsb:RAddrLsb];
        s_addr_o     = instr_i[SAddrMsb:SAddrLsb];
        s_sel_o      = instr_i[SSelBit];
        imm          = instr_i[ImmMsb:ImmLsb];
        ds_o         = {8{imm}};
        is_mac_o     = is_mac(instr_i[VModeMsb:VModeLsb]);
        is_illegal_o = (instr_i[AluOpMsb:AluOpLsb] == ILLEGAL_OP);
    end

endmodule

// File: rtl/vector_dp_sequencer.sv
// Issue controller for the vector datapath. Accepts instructions over a
// valid/ready handshake and drives the datapath control inputs. Non-MAC ops
// retire in one cycle; MAC modes run a MUL phase (MANDA load) then an ADD
// phase (regfile write-back).
// Ports:
//   W_Clk, Reset (synchronous, active-high)
//   In_Valid / In_Ready / In_Instr    instruction handshake
//   Hold                              freeze: no enables, state held
//   W_En, MANDA_En                    write enables
//   W_Addr, R_Addr, S_Addr, ALU_Op, V_Mode, S_Sel, DS   control fields
//   Busy, Done, Err                   status
// Optional: define VDP_SEQ_STATS_EN to add Instr_Cnt / Mac_Cnt counters.
module vector_dp_sequencer
    import vdp_seq_pkg::*;
(
    input  logic             W_Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [31:0]      In_Instr,
    input  logic             Hold,
    output logic             W_En,
    output logic             MANDA_En,
    output logic [4:0]       W_Addr,
    output logic [4:0]       R_Addr,
    output logic [4:0]       S_Addr,
    output logic [4:0]       ALU_Op,
    output logic [2:0]       V_Mode,
    output logic             S_Sel,
    output logic [63:0]      DS,
    output logic             Busy,
    output logic             Done,
`ifdef VDP_SEQ_STATS_EN
    output logic [CNT_W-1:0] Instr_Cnt,
    output logic [CNT_W-1:0] Mac_Cnt,
`endif
    output logic             Err
);

    logic [2:0]  dec_v_mode;
    logic [4:0]  dec_alu_op, dec_w_addr, dec_r_addr, dec_s_addr;
    logic        dec_s_sel, dec_is_mac, dec_is_illegal;
    logic [63:0] dec_ds;

    vdp_seq_decode u_decode (
        .instr_i      (In_Instr),
        .v_mode_o     (dec_v_mode),
        .alu_op_o     (dec_alu_op),
        .w_addr_o     (dec_w_addr),
        .r_addr_o     (dec_r_addr),
        .s_addr_o     (dec_s_addr),
        .s_sel_o      (dec_s_sel),
        .ds_o         (dec_ds),
        .is_mac_o     (dec_is_mac),
        .is_illegal_o (dec_is_illegal)
    );

    state_e      state_q, state_d;
    logic        w_en_q, w_en_d;
    logic        manda_en_q, manda_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [4:0]  r_addr_q, r_addr_d;
    logic [4:0]  s_addr_q, s_addr_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [4:0]  mac_op_q, mac_op_d;   // ALU_Op to drive in the ADD phase
    logic [2:0]  v_mode_q, v_mode_d;
    logic        s_sel_q, s_sel_d;
    logic [63:0] ds_q, ds_d;
    logic        accept;

    assign In_Ready = !Reset && !Hold && (state_q != StMul);
    assign accept   = In_Valid && In_Ready;

    always_comb begin
        state_d    = state_q;
        w_en_d     = w_en_q;
        manda_en_d = manda_en_q;
        done_d     = done_q;
        w_addr_d   = w_addr_q;
        r_addr_d   = r_addr_q;
        s_addr_d   = s_addr_q;
        alu_op_d   = alu_op_q;
        mac_op_d   = mac_op_q;
        v_mode_d   = v_mode_q;
        s_sel_d    = s_sel_q;
        ds_d       = ds_q;
        // Err is a pulse tied to the accept edge, so it is never frozen by Hold
        err_d      = accept && dec_is_illegal;

        // Under Hold everything keeps its value; the held phase re-drives on release
        if (!Hold) begin
            w_en_d     = 1'b0;
            manda_en_d = 1'b0;
            done_d     = 1'b0;
            unique case (state_q)
                StMul: begin
                    state_d  = StAdd;
                    alu_op_d = mac_op_q;
                    w_en_d   = 1'b1;
                    done_d   = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                    if (accept && !dec_is_illegal) begin
                        w_addr_d = dec_w_addr;
                        r_addr_d = dec_r_addr;
                        s_addr_d = dec_s_addr;
                        v_mode_d = dec_v_mode;
                        s_sel_d  = dec_s_sel;
                        ds_d     = dec_ds;
                        if (dec_is_mac) begin
                            state_d    = StMul;
                            alu_op_d   = MUL_OP;
                            mac_op_d   = dec_alu_op;
                            manda_en_d = 1'b1;
                        end else begin
                            state_d  = StExec;
                            alu_op_d = dec_alu_op;
                            w_en_d   = 1'b1;
                            done_d   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge W_Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            w_en_q     <= 1'b0;
            manda_en_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            w_addr_q   <= '0;
            r_addr_q   <= '0;
            s_addr_q   <= '0;
            alu_op_q   <= '0;
            mac_op_q   <= '0;
            v_mode_q   <= ModeNib4;
            s_sel_q    <= 1'b0;
            ds_q       <= '0;
        end else begin
            state_q    <= state_d;
            w_en_q     <= w_en_d;
            manda_en_q <= manda_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            w_addr_q   <= w_addr_d;
            r_addr_q   <= r_addr_d;
            s_addr_q   <= s_addr_d;
            alu_op_q   <= alu_op_d;
            mac_op_q   <= mac_op_d;
            v_mode_q   <= v_mode_d;
            s_sel_q    <= s_sel_d;
            ds_q       <= ds_d;
        end
    end

    // Enables are masked by Hold and Reset so a held or aborted phase never
    // commits a write in the cycle it is suppressed.
    assign W_En     = w_en_q && !Hold && !Reset;
    assign MANDA_En = manda_en_q && !Hold && !Reset;
    assign Done     = done_q && !Hold && !Reset;
    assign Err      = err_q;
    assign Busy     = (state_q != StIdle);
    assign W_Addr   = w_addr_q;
    assign R_Addr   = r_addr_q;
    assign S_Addr   = s_addr_q;
    assign ALU_Op   = alu_op_q;
    assign V_Mode   = v_mode_q;
    assign S_Sel    = s_sel_q;
    assign DS       = ds_q;

`ifdef VDP_SEQ_STATS_EN
    logic [CNT_W-1:0] instr_cnt_q, mac_cnt_q;

    always_ff @(posedge W_Clk) begin
        if (Reset) begin
            instr_cnt_q <= '0;
            mac_cnt_q   <= '0;
        end else if (Done) begin
            instr_cnt_q <= instr_cnt_q + 1'b1;
            if (state_q == StAdd) begin
                mac_cnt_q <= mac_cnt_q + 1'b1;
            end
        end
    end

    assign Instr_Cnt = instr_cnt_q;
    assign Mac_Cnt   = mac_cnt_q;
`endif

endmodule

// File: tb/tb_vector_dp_sequencer.sv
// Scoreboard bench for vector_dp_sequencer: the monitor compares every enable
// event against a queue of expected datapath actions built from accepted
// instructions.
module tb_vector_dp_sequencer;

    logic        W_Clk = 1'b0;
    logic        Reset, In_Valid, In_Ready, Hold;
    logic [31:0] In_Instr;
    logic        W_En, MANDA_En, S_Sel, Busy, Done, Err;
    logic [4:0]  W_Addr, R_Addr, S_Addr, ALU_Op;
    logic [2:0]  V_Mode;
    logic [63:0] DS;
`ifdef VDP_SEQ_STATS_EN
    logic [15:0] Instr_Cnt, Mac_Cnt;
`endif

    vector_dp_sequencer dut (
        .W_Clk    (W_Clk),
        .Reset    (Reset),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_Instr (In_Instr),
        .Hold     (Hold),
        .W_En     (W_En),
        .MANDA_En (MANDA_En),
        .W_Addr   (W_Addr),
        .R_Addr   (R_Addr),
        .S_Addr   (S_Addr),
        .ALU_Op   (ALU_Op),
        .V_Mode   (V_Mode),
        .S_Sel    (S_Sel),
        .DS       (DS),
        .Busy     (Busy),
        .Done     (Done),
`ifdef VDP_SEQ_STATS_EN
        .Instr_Cnt(Instr_Cnt),
        .Mac_Cnt  (Mac_Cnt),
`endif
        .Err      (Err)
    );

    always #5 W_Clk = ~W_Clk;

    // One expected datapath action: a MANDA load (mul=1) or a regfile write
    typedef struct {
        bit          mul;
        logic [4:0]  w, r, s, op;
        logic [2:0]  mode;
        logic        ssel;
        logic [63:0] ds;
        int          due;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   mul_pending = 0;
    bit   err_exp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] mode, input logic [4:0] op,
                                       input logic [4:0] w, input logic [4:0] r,
                                       input logic [4:0] s, input logic ssel,
                                       input logic [7:0] imm);
        return {mode, op, w, r, s, ssel, imm};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic h, input logic r);
        @(posedge W_Clk);
        #1;
        In_Valid = v;
        In_Instr = ins;
        Hold     = h;
        Reset    = r;
    endtask

    // Monitor / scoreboard
    always @(negedge W_Clk) begin : monitor
        ev_t         e;
        logic        exp_ready, due_now, got, err_n;
        logic [4:0]  op;
        logic [2:0]  mode;
        if (mon_en) begin
            cyc++;
            exp_ready = !Reset && !Hold && !mul_pending;
            chk("in_ready", In_Ready, exp_ready);
            if (Reset || Hold) begin
                chk("w_en_suppressed", W_En, 1'b0);
                chk("manda_en_suppressed", MANDA_En, 1'b0);
                chk("done_suppressed", Done, 1'b0);
            end else begin
                due_now = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
                got     = W_En || MANDA_En;
                chk("event_presence", got, due_now);
                if (got && due_now) begin
                    e = exp_q.pop_front();
                    chk("manda_en", MANDA_En, e.mul);
                    chk("w_en", W_En, !e.mul);
                    chk("done", Done, !e.mul);
                    chk("busy", Busy, 1'b1);
                    chk("alu_op", ALU_Op, e.op);
                    chk("v_mode", V_Mode, e.mode);
                    chk("w_addr", W_Addr, e.w);
                    chk("r_addr", R_Addr, e.r);
                    chk("s_addr", S_Addr, e.s);
                    chk("s_sel", S_Sel, e.ssel);
                    chk("ds", DS, e.ds);
                    if (e.mul) begin
                        mul_pending = 0;
                        if (exp_q.size() > 0) exp_q[0].due = cyc + 1;
                    end
                end
            end
            chk("err", Err, err_exp);
            err_n = 0;
            if (Reset) begin
                exp_q.delete();
                mul_pending = 0;
            end else if (In_Valid && exp_ready) begin
                op   = In_Instr[28:24];
                mode = In_Instr[31:29];
                e.w    = In_Instr[23:19];
                e.r    = In_Instr[18:14];
                e.s    = In_Instr[13:9];
                e.ssel = In_Instr[8];
                e.ds   = {8{In_Instr[7:0]}};
                e.mode = mode;
                if (op == 5'h1F) begin
                    err_n = 1;
                end else if (mode >= 3'd5) begin
                    e.mul = 1; e.op = 5'h0A; e.due = cyc + 1;
                    exp_q.push_back(e);
                    e.mul = 0; e.op = op; e.due = 32'h7fff_ffff;
                    exp_q.push_back(e);
                    mul_pending = 1;
                end else begin
                    e.mul = 0; e.op = op; e.due = cyc + 1;
                    exp_q.push_back(e);
                end
            end
            err_exp = err_n;
        end
    end

    initial begin
        logic [31:0] ins;
        Reset    = 1'b1;
        Hold     = 1'b0;
        In_Valid = 1'b1;
        In_Instr = mk(3'd1, 5'h02, 5'd7, 5'd6, 5'd5, 1'b1, 8'h3C);
        @(posedge W_Clk);
        #1 mon_en = 1;
        @(posedge W_Clk);
        @(posedge W_Clk);
        #1;
        Reset    = 1'b0;
        In_Valid = 1'b0;
        @(negedge W_Clk);
        chk("rst_w_en", W_En, 1'b0);
        chk("rst_manda_en", MANDA_En, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_fields", {W_Addr, R_Addr, S_Addr, ALU_Op, V_Mode, S_Sel}, 64'd0);
        chk("rst_ds", DS, 64'd0);
        chk("rst_ready_after", In_Ready, 1'b1);

        // Single non-MAC op with immediate replication
        drive(1, mk(3'd1, 5'h02, 5'd3, 5'd1, 5'd2, 1'b1, 8'hA5), 0, 0);
        drive(0, 32'd0, 0, 0);
        drive(0, 32'd0, 0, 0);
        // Three back-to-back non-MAC
        drive(1, mk(3'd3, 5'h01, 5'd4, 5'd5, 5'd6, 1'b0, 8'h11), 0, 0);
        drive(1, mk(3'd3, 5'h03, 5'd7, 5'd8, 5'd9, 1'b1, 8'h22), 0, 0);
        drive(1, mk(3'd3, 5'h05, 5'd10, 5'd11, 5'd12, 1'b0, 8'h33), 0, 0);
        drive(0, 32'd0, 0, 0);
        // MAC
        drive(1, mk(3'd6, 5'h04, 5'd13, 5'd14, 5'd15, 1'b1, 8'h5A), 0, 0);
        drive(0, 32'd0, 0, 0);
        drive(0, 32'd0, 0, 0);
        drive(0, 32'd0, 0, 0);
        // MAC with Hold for two cycles during MUL
        drive(1, mk(3'd7, 5'h06, 5'd16, 5'd17, 5'd18, 1'b0, 8'hC3), 0, 0);
        drive(0, 32'd0, 1, 0);
        drive(0, 32'd0, 1, 0);
        drive(0, 32'd0, 0, 0);
        drive(0, 32'd0, 0, 0);
        drive(0, 32'd0, 0, 0);
        // Illegal op, then MAC aborted by Reset in ADD
        drive(1, mk(3'd2, 5'h1F, 5'd19, 5'd20, 5'd21, 1'b1, 8'hFF), 0, 0);
        drive(0, 32'd0, 0, 0);
        drive(1, mk(3'd5, 5'h07, 5'd22, 5'd23, 5'd24, 1'b0, 8'h0F), 0, 0);
        drive(0, 32'd0, 0, 0);
        drive(0, 32'd0, 0, 1);
        drive(0, 32'd0, 0, 0);
        drive(0, 32'd0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) == 0) ins[28:24] = 5'h1F;
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 63) == 0);
        end
        for (int i = 0; i < 10; i++) drive(0, 32'd0, 0, 0);
        @(negedge W_Clk);
        #1;
        chk("drain_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
